instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Purpose: the fetch stage of a pipeline. It holds the PC, drives the
// instruction memory address, and registers the fetched word and its PC+4
// into the IF/ID pipeline register. Branch and jump redirects, stall, flush
// and a halt instruction control how the PC advances.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on redirect targets
// whose bits[1:0] are not zero. The trap sets a sticky MisalignErr flag and
// halts fetch. When the macro is undefined, the low two target bits are
// cleared and MisalignErr is tied to 0.
//
// Ports:
//   Clk              in   rising-edge clock
//   Rst              in   synchronous active-high reset
//   Stall            in   hold the PC and IF/ID contents
//   Flush            in   replace the word being fetched with a bubble
//   BranchTaken      in   resolved taken branch (wins over Jump)
//   BranchTarget     in   [31:0] branch destination byte address
//   Jump             in   jump decoded
//   JumpTarget       in   [31:0] jump destination byte address
//   IMemAddress      out  [31:0] instruction memory address (= PC)
//   IMemInstruction  in   [31:0] combinational read data at IMemAddress
//   IFID_Instruction out  [31:0] registered instruction
//   IFID_PCPlus4     out  [31:0] registered PC+4 of that instruction
//   IFID_Valid       out  IF/ID holds a real instruction
//   Halted           out  fetch stopped by HALT_WORD (or by a misalign trap)
//   MisalignErr      out  sticky misaligned-target flag
//   dbg_state        out  [1:0] current FSM state (0 FILL, 1 RUN, 2 HALTED)
//
// Handshake: there is no valid/ready pair on this block. IF/ID content is
// meaningful only while IFID_Valid=1, and a consumer holds off by raising
// Stall. Stall freezes the PC and the IF/ID register for as long as it is
// held, unless a redirect or Flush arrives in the same cycle.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic        MisalignErr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] pc_plus4;

  assign redirect   = BranchTaken | Jump;
  assign raw_target = BranchTaken ? BranchTarget : JumpTarget;
  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 becomes 0.
  assign pc_plus4   = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    ifid_valid_d = ifid_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif

    case (state_q)
      // One cycle in which the PC is presented to memory but nothing is
      // captured yet, so the first real fetch happens from RESET_PC.
      ST_FILL: begin
        state_d      = ST_RUN;
        ifid_instr_d = 32'd0;
        ifid_pcp4_d  = 32'd0;
        ifid_valid_d = 1'b0;
      end

      ST_RUN: begin
        if (redirect) begin
          ifid_instr_d = 32'd0;
          ifid_pcp4_d  = 32'd0;
          ifid_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (raw_target[1:0] != 2'b00) begin
            // The PC keeps its pre-redirect value so the fault site is visible.
            misalign_d = 1'b1;
            state_d    = ST_HALTED;
          end else begin
            pc_d = raw_target;
          end
`else
          pc_d = raw_target & ~32'd3;
`endif
        end else if (Flush) begin
          pc_d         = pc_plus4;
          ifid_instr_d = 32'd0;
          ifid_pcp4_d  = 32'd0;
          ifid_valid_d = 1'b0;
        end else if (!Stall) begin
          pc_d         = pc_plus4;
          ifid_instr_d = IMemInstruction;
          ifid_pcp4_d  = pc_plus4;
          ifid_valid_d = 1'b1;
          // The halt word itself goes down the pipe as a valid instruction.
          if (IMemInstruction == HALT_WORD) begin
            state_d = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
        ifid_instr_d = 32'd0;
        ifid_pcp4_d  = 32'd0;
        ifid_valid_d = 1'b0;
      end

      default: begin
        state_d      = ST_FILL;
        ifid_instr_d = 32'd0;
        ifid_pcp4_d  = 32'd0;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_FILL;
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'd0;
      ifid_pcp4_q  <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign MisalignErr = misalign_q;
`else
  assign MisalignErr = 1'b0;
`endif

  assign IMemAddress      = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pcp4_q;
  assign IFID_Valid       = ifid_valid_q;
  assign Halted           = (state_q == ST_HALTED);
  assign dbg_state        = state_q;

endmodule
